io_bus_master: RTL and testbench
================================

# io_bus_master

Initiator side of the processor I/O bus: accepts a single read or write request from the core and turns it into a timed bus cycle. It drives the 2-bit group select ADHI, the 3-bit port select ADIO and one-bit READ/WRITE strobes consumed by the address decoder. It drives write data, captures read data, and returns a one-cycle response to the core. It sits between the core's I/O execute stage and the address decoder / I/O device groups.

## Interface
- SETUP_CYC, 1: cycles address is stable before the strobe (≥1)
- STROBE_CYC, 2: cycles READ/WRITE is asserted (≥1)
- HOLD_CYC, 1: cycles address/data held after the strobe (≥1)
- DW, 16: data width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  block can accept a request
- req_write  in  1  1=write, 0=read
- req_addr  in  5  {group[1:0], port[2:0]}
- req_wdata  in  DW  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DW  captured read data (0 after a write)
- ADHI  out  2  group select to decoder
- ADIO  out  3  port select to decoder
- READ  out  1  read strobe
- WRITE  out  1  write strobe
- io_dout  out  DW  write data to devices
- io_oe  out  1  io_dout drive enable
- io_din  in  DW  read data from devices
- io_wait  in  1  device stretch request (only with IO_WAIT_EN)

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD. One phase down-counter is loaded on each state entry.
- req_ready = (state==IDLE). It is decoded from the state register, with no combinational path from req_valid.
- Acceptance happens when req_valid & req_ready at an edge. On that edge:
  - ADHI/ADIO load req_addr[4:3]/req_addr[2:0].
  - io_dout loads req_wdata on a write.
  - The op type is latched.
  - The state moves to SETUP.
- SETUP lasts SETUP_CYC cycles. Strobes are low. io_oe=1 for writes.
- STROBE lasts STROBE_CYC cycles. READ (read) or WRITE (write) is 1. Exactly one strobe is high, never both.
- Read capture: on the edge ending the last STROBE cycle, rsp_rdata ← io_din.
- HOLD lasts HOLD_CYC cycles. Strobes are low. ADHI/ADIO/io_dout/io_oe are held.
- Completion: the state returns to IDLE and rsp_valid=1 for exactly that first IDLE cycle. io_oe→0.
- In IDLE, ADHI/ADIO/io_dout keep their last values. rsp_rdata holds until the next completion. A write completion sets rsp_rdata=0.
- All outputs are registered.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, ADHI=0, ADIO=0, READ=0, WRITE=0, io_dout=0, io_oe=0.
- Defaults, with acceptance at edge ending cycle 0:
  - SETUP in cycle 1.
  - Strobe in cycles 2–3.
  - HOLD in cycle 4.
  - rsp_valid and req_ready in cycle 5.
- Latency from acceptance to rsp_valid is SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles.
- Back-to-back: a request presented during the rsp_valid cycle is accepted at that edge. Minimum issue interval is SETUP_CYC+STROBE_CYC+HOLD_CYC+1.
- req_* changes while the block is not ready are ignored. No buffering.
- Reset mid-cycle: all outputs go to reset values immediately (asynchronous). The in-flight op is dropped, and no rsp_valid is issued for it.

## Configuration
- IO_WAIT_EN defined:
  - In the last STROBE cycle, if io_wait=1, the counter does not expire and the strobe stays high. The state stays in STROBE until the first cycle with io_wait=0.
  - Read capture happens on the edge ending that cycle.
  - io_wait is ignored in other states.
- IO_WAIT_EN undefined: the io_wait port is absent, and strobe length is exactly STROBE_CYC.

## Structure
- Shared package io_bus_pkg holds:
  - the state enum (IDLE/SETUP/STROBE/HOLD);
  - ADHI_W=2 and ADIO_W=3;
  - the default DW=16.
- The address decoder imports the same widths.
- Sub-module io_phase_timer: a loadable down-counter with load value, load, and expire (and, with IO_WAIT_EN, a stall input). It is instantiated once.

## Test plan
- Reset is held, then released: all outputs read 0 and req_ready=1.
- Read, req_addr=5'b10_011, io_din=16'hBEEF in cycles 2–3: ADHI=2, ADIO=3, and READ is high in cycles 2–3 only. rsp_valid is high in cycle 5 with rsp_rdata=16'hBEEF, and WRITE stays 0 throughout.
- Write, req_addr=5'b01_111, wdata=16'h1234: io_dout=16'h1234 and io_oe=1 in cycles 1–4, WRITE is high in cycles 2–3, and rsp_valid is high in cycle 5 with rsp_rdata=0.
- Two requests back-to-back (write then read), with the second held valid throughout: the second is accepted in the first's rsp_valid cycle, and its strobes start 2 cycles later with no overlap.
- Reset is asserted in cycle 2 of a read: READ drops immediately, no rsp_valid follows, and the next request runs normally.
- With IO_WAIT_EN, io_wait=1 for 3 cycles from cycle 3: READ stays high for cycles 2–6, data is captured at the end of cycle 6, and rsp_valid is high in cycle 8.

Source files
------------

// File: rtl/io_bus_pkg.sv
// io_bus_pkg: shared state encoding and bus widths for the I/O bus master and address decoder
package io_bus_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} io_state_e;
  localparam int ADHI_W = 2;
  localparam int ADIO_W = 3;
  localparam int DW_DEF = 16;
  localparam int CNT_W = 8;
endpackage

// File: rtl/io_phase_timer.sv
// io_phase_timer: loadable phase down-counter; IO_WAIT_EN adds a stall input that blocks expiry
module io_phase_timer
  import io_bus_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
`ifdef IO_WAIT_EN
  input  logic             stall_i,
`endif
  output logic             expire_o
);
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else if (load_i) cnt_q <= load_val_i;
    else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
`ifdef IO_WAIT_EN
  assign expire_o = (cnt_q == '0) && !stall_i;
`else
  assign expire_o = (cnt_q == '0);
`endif
endmodule

// File: rtl/io_bus_master.sv
// io_bus_master: I/O bus initiator turning core requests into timed bus cycles; IO_WAIT_EN enables io_wait strobe stretching
module io_bus_master
  import io_bus_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int DW         = DW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [4:0]        req_addr,
  input  logic [DW-1:0]     req_wdata,
  output logic              rsp_valid,
  output logic [DW-1:0]     rsp_rdata,
  output logic [ADHI_W-1:0] ADHI,
  output logic [ADIO_W-1:0] ADIO,
  output logic              READ,
  output logic              WRITE,
  output logic [DW-1:0]     io_dout,
  output logic              io_oe,
  input  logic [DW-1:0]     io_din
`ifdef IO_WAIT_EN
  ,
  input  logic              io_wait
`endif
);
  io_state_e         state_q;
  logic              wr_q, rsp_valid_q, read_q, write_q, oe_q;
  logic [DW-1:0]     rdata_q, dout_q;
  logic [ADHI_W-1:0] adhi_q;
  logic [ADIO_W-1:0] adio_q;
  logic              expire, tload;
  logic [CNT_W-1:0]  tval;
  // The counter is reloaded on every state entry with the length of the phase being entered
  assign tload = (state_q == IDLE) ? req_valid : (state_q == SETUP || state_q == STROBE) ? expire : 1'b0;
  assign tval = (state_q == IDLE) ? CNT_W'(SETUP_CYC - 1) : (state_q == SETUP) ? CNT_W'(STROBE_CYC - 1) : CNT_W'(HOLD_CYC - 1);
  io_phase_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tload),
    .load_val_i (tval),
`ifdef IO_WAIT_EN
    .stall_i    (state_q == STROBE && io_wait),
`endif
    .expire_o   (expire)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      oe_q        <= 1'b0;
      rdata_q     <= '0;
      dout_q      <= '0;
      adhi_q      <= '0;
      adio_q      <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (req_valid) begin
          adhi_q  <= req_addr[4:3];
          adio_q  <= req_addr[2:0];
          wr_q    <= req_write;
          oe_q    <= req_write;
          if (req_write) dout_q <= req_wdata;
          state_q <= SETUP;
        end
        SETUP: if (expire) begin
          read_q  <= !wr_q;
          write_q <= wr_q;
          state_q <= STROBE;
        end
        STROBE: if (expire) begin
          read_q  <= 1'b0;
          write_q <= 1'b0;
          if (!wr_q) rdata_q <= io_din;
          state_q <= HOLD;
        end
        HOLD: if (expire) begin
          oe_q        <= 1'b0;
          rsp_valid_q <= 1'b1;
          if (wr_q) rdata_q <= '0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign ADHI      = adhi_q;
  assign ADIO      = adio_q;
  assign READ      = read_q;
  assign WRITE     = write_q;
  assign io_dout   = dout_q;
  assign io_oe     = oe_q;
endmodule

// File: tb/tb_io_bus_master.sv
// tb_io_bus_master: directed table-driven bench for io_bus_master with default timing parameters
module tb_io_bus_master;
  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [4:0]  req_addr = '0;
  logic [15:0] req_wdata = '0, io_din = 16'hDEAD;
  logic        req_ready, rsp_valid, READ, WRITE, io_oe;
  logic [15:0] rsp_rdata, io_dout;
  logic [1:0]  ADHI;
  logic [2:0]  ADIO;
`ifdef IO_WAIT_EN
  logic        io_wait = 1'b0;
`endif
  int n_chk = 0, n_fail = 0;

  io_bus_master dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .ADHI(ADHI), .ADIO(ADIO),
    .READ(READ), .WRITE(WRITE), .io_dout(io_dout), .io_oe(io_oe), .io_din(io_din)
`ifdef IO_WAIT_EN
    , .io_wait(io_wait)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [15:0] wdata;
    logic [15:0] din;
    logic [1:0]  exp_adhi;
    logic [2:0]  exp_adio;
    logic [15:0] exp_rdata;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    @(negedge clk);
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      req_addr = 5'h1f; req_wdata = 16'h0bad; req_write = !v.wr;
      io_din = (c == 2 || c == 3) ? v.din : 16'hDEAD;
      chk($sformatf("v%0d READ c%0d", idx, c), READ, !v.wr && (c == 2 || c == 3));
      chk($sformatf("v%0d WRITE c%0d", idx, c), WRITE, v.wr && (c == 2 || c == 3));
      chk($sformatf("v%0d io_oe c%0d", idx, c), io_oe, v.wr && c <= 4);
      chk($sformatf("v%0d rsp_valid c%0d", idx, c), rsp_valid, c == 5);
      chk($sformatf("v%0d req_ready c%0d", idx, c), req_ready, c == 5);
      chk($sformatf("v%0d ADHI c%0d", idx, c), ADHI, v.exp_adhi);
      chk($sformatf("v%0d ADIO c%0d", idx, c), ADIO, v.exp_adio);
      if (v.wr) chk($sformatf("v%0d io_dout c%0d", idx, c), io_dout, v.wdata);
    end
    chk($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
    io_din = 16'hDEAD;
  endtask

  initial begin
    vecs[0] = '{1'b0, 5'b10_011, 16'h0000, 16'hBEEF, 2'd2, 3'd3, 16'hBEEF};
    vecs[1] = '{1'b1, 5'b01_111, 16'h1234, 16'h5555, 2'd1, 3'd7, 16'h0000};
    vecs[2] = '{1'b0, 5'b11_101, 16'h0000, 16'hA5A5, 2'd3, 3'd5, 16'hA5A5};
    vecs[3] = '{1'b0, 5'b00_000, 16'h0000, 16'h0001, 2'd0, 3'd0, 16'h0001};
    vecs[4] = '{1'b1, 5'b10_010, 16'hFFFF, 16'h7777, 2'd2, 3'd2, 16'h0000};

    repeat (3) @(negedge clk);
    chk("reset req_ready", req_ready, 1);
    chk("reset outputs", {rsp_valid, rsp_rdata, ADHI, ADIO, READ, WRITE, io_dout, io_oe}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post-reset req_ready", req_ready, 1);
    chk("post-reset outputs", {rsp_valid, rsp_rdata, ADHI, ADIO, READ, WRITE, io_dout, io_oe}, 0);

    for (int i = 0; i < 5; i++) run_txn(vecs[i], i);

    // Back-to-back: write then read, second request held valid from cycle 1
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'b01_001; req_wdata = 16'hC0DE;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin req_write = 1'b0; req_addr = 5'b11_110; end
      if (c == 6) req_valid = 1'b0;
      io_din = (c == 7 || c == 8) ? 16'h9A9A : 16'hDEAD;
      chk($sformatf("b2b WRITE c%0d", c), WRITE, c == 2 || c == 3);
      chk($sformatf("b2b READ c%0d", c), READ, c == 7 || c == 8);
      chk($sformatf("b2b rsp_valid c%0d", c), rsp_valid, c == 5 || c == 10);
      chk($sformatf("b2b req_ready c%0d", c), req_ready, c == 5 || c == 10);
      if (c == 5) chk("b2b rdata after write", rsp_rdata, 16'h0000);
      if (c >= 6) chk($sformatf("b2b ADDR c%0d", c), {ADHI, ADIO}, 5'b11_110);
    end
    chk("b2b rdata after read", rsp_rdata, 16'h9A9A);
    io_din = 16'hDEAD;

    // Reset during cycle 2 of a read
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'b10_101;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    chk("rst-mid READ before", READ, 1);
    #1 reset = 1'b1;
    #1;
    chk("rst-mid READ dropped", READ, 0);
    chk("rst-mid outputs", {rsp_valid, rsp_rdata, ADHI, ADIO, READ, WRITE, io_dout, io_oe}, 0);
    chk("rst-mid req_ready", req_ready, 1);
    @(negedge clk); reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("rst-mid no rsp c%0d", c), {rsp_valid, READ, WRITE}, 0);
    end
    run_txn(vecs[0], 10);

`ifdef IO_WAIT_EN
    // io_wait high in cycles 3-5 stretches the read strobe to cycle 6
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'b01_010;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      io_wait = (c >= 3 && c <= 5);
      io_din = (c == 6) ? 16'h4321 : 16'hDEAD;
      chk($sformatf("wait READ c%0d", c), READ, c >= 2 && c <= 6);
      chk($sformatf("wait rsp_valid c%0d", c), rsp_valid, c == 8);
    end
    io_wait = 1'b0;
    chk("wait rsp_rdata", rsp_rdata, 16'h4321);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
